// File: rtl/axis_word_serializer.sv
// Wide-to-narrow AXI-Stream adapter: one IN_BYTES word in, one byte per beat out, sideband held per word.
// Latency: first byte one cycle after the word is accepted; 1 byte/clk sustained, no bubble between words.
// Backpressure: input ready only when empty or while the final byte of the held word is handshaking.
module axis_word_serializer #(
    parameter int IN_BYTES   = 4,
    parameter int ID_WIDTH   = 8,
    parameter int DEST_WIDTH = 8,
    parameter int USER_WIDTH = 1,
    parameter int MSB_FIRST  = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [8*IN_BYTES-1:0]   s_axis_tdata,
    input  logic [IN_BYTES-1:0]     s_axis_tkeep,
    input  logic                    s_axis_tvalid,
    output logic                    s_axis_tready,
    input  logic                    s_axis_tlast,
    input  logic [ID_WIDTH-1:0]     s_axis_tid,
    input  logic [DEST_WIDTH-1:0]   s_axis_tdest,
    input  logic [USER_WIDTH-1:0]   s_axis_tuser,
    output logic [7:0]              m_axis_tdata,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic                    m_axis_tlast,
    output logic [ID_WIDTH-1:0]     m_axis_tid,
    output logic [DEST_WIDTH-1:0]   m_axis_tdest,
    output logic [USER_WIDTH-1:0]   m_axis_tuser,
    output logic                    err_null_last
);

    localparam int IDX_W = $clog2(IN_BYTES);

    typedef enum logic {EMPTY, SHIFT} state_t;

    state_t                  state_q, state_d;
    logic [8*IN_BYTES-1:0]   data_q, data_d;
    logic [IN_BYTES-1:0]     keep_q, keep_d;
    logic                    last_q, last_d;
    logic [ID_WIDTH-1:0]     id_q, id_d;
    logic [DEST_WIDTH-1:0]   dest_q, dest_d;
    logic [USER_WIDTH-1:0]   user_q, user_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic                    err_q, err_d;

    logic [IN_BYTES-1:0]     kord;
    logic [IDX_W-1:0]        last_idx;
    logic                    run;
    logic [IDX_W-1:0]        sel;
    logic                    at_last;
    logic                    s_hs;

    // Keep bits reordered into emission order; only the leading contiguous run is emitted.
    always_comb begin
        kord     = '0;
        last_idx = '0;
        run      = 1'b1;
        for (int i = 0; i < IN_BYTES; i++) begin
            kord[i] = (MSB_FIRST != 0) ? keep_q[IN_BYTES-1-i] : keep_q[i];
        end
        for (int i = 0; i < IN_BYTES; i++) begin
            if (run && kord[i]) begin
                last_idx = IDX_W'(i);
            end else begin
                run = 1'b0;
            end
        end
    end

    assign sel     = (MSB_FIRST != 0) ? (IDX_W'(IN_BYTES - 1) - idx_q) : idx_q;
    assign at_last = (state_q == SHIFT) && (idx_q == last_idx);

    assign s_axis_tready = rst && ((state_q == EMPTY) || (at_last && m_axis_tready));
    assign s_hs          = s_axis_tvalid && s_axis_tready;

    assign m_axis_tvalid = (state_q == SHIFT);
    assign m_axis_tdata  = (state_q == SHIFT) ? data_q[8*sel +: 8] : 8'd0;
    assign m_axis_tlast  = at_last && last_q;
    assign m_axis_tid    = id_q;
    assign m_axis_tdest  = dest_q;
    assign m_axis_tuser  = user_q;
    assign err_null_last = err_q;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        keep_d  = keep_q;
        last_d  = last_q;
        id_d    = id_q;
        dest_d  = dest_q;
        user_d  = user_q;
        idx_d   = idx_q;
        err_d   = 1'b0;

        if ((state_q == SHIFT) && m_axis_tready) begin
            if (idx_q != last_idx) begin
                idx_d = idx_q + 1'b1;
            end else begin
                state_d = EMPTY;
            end
        end

        // A new word can only land when empty or on the final byte, so it overrides the advance above.
        if (s_hs) begin
            if (s_axis_tkeep != '0) begin
                data_d  = s_axis_tdata;
                keep_d  = s_axis_tkeep;
                last_d  = s_axis_tlast;
                id_d    = s_axis_tid;
                dest_d  = s_axis_tdest;
                user_d  = s_axis_tuser;
                idx_d   = '0;
                state_d = SHIFT;
            end else begin
                state_d = EMPTY;
                err_d   = s_axis_tlast;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= EMPTY;
            data_q  <= '0;
            keep_q  <= '0;
            last_q  <= 1'b0;
            id_q    <= '0;
            dest_q  <= '0;
            user_q  <= '0;
            idx_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            keep_q  <= keep_d;
            last_q  <= last_d;
            id_q    <= id_d;
            dest_q  <= dest_d;
            user_q  <= user_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_axis_word_serializer.sv
// Bench for axis_word_serializer: LSB-first and MSB-first instances side by side, scoreboard-checked.
module tb_axis_word_serializer;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] s_tdata [2];
    logic [3:0]  s_tkeep [2];
    logic        s_tvalid[2];
    logic        s_tready[2];
    logic        s_tlast [2];
    logic [7:0]  s_tid   [2];
    logic [7:0]  s_tdest [2];
    logic [0:0]  s_tuser [2];
    logic [7:0]  m_tdata [2];
    logic        m_tvalid[2];
    logic        m_tready[2];
    logic        m_tlast [2];
    logic [7:0]  m_tid   [2];
    logic [7:0]  m_tdest [2];
    logic [0:0]  m_tuser [2];
    logic        err     [2];

    for (genvar g = 0; g < 2; g++) begin : gen_dut
        axis_word_serializer #(
            .IN_BYTES(4), .ID_WIDTH(8), .DEST_WIDTH(8), .USER_WIDTH(1), .MSB_FIRST(g)
        ) u_dut (
            .clk(clk), .rst(rst),
            .s_axis_tdata(s_tdata[g]), .s_axis_tkeep(s_tkeep[g]),
            .s_axis_tvalid(s_tvalid[g]), .s_axis_tready(s_tready[g]),
            .s_axis_tlast(s_tlast[g]), .s_axis_tid(s_tid[g]),
            .s_axis_tdest(s_tdest[g]), .s_axis_tuser(s_tuser[g]),
            .m_axis_tdata(m_tdata[g]), .m_axis_tvalid(m_tvalid[g]),
            .m_axis_tready(m_tready[g]), .m_axis_tlast(m_tlast[g]),
            .m_axis_tid(m_tid[g]), .m_axis_tdest(m_tdest[g]),
            .m_axis_tuser(m_tuser[g]), .err_null_last(err[g])
        );
    end

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int mode[2];          // 0: sink always ready, 1: pseudo-random ready
    int errcnt[2];
    int last_cyc[2];
    logic        stall[2];
    logic [25:0] prev[2];
    // Entry: [26] final kept byte, [25] user, [24:17] dest, [16:9] id, [8] tlast, [7:0] data
    logic [26:0] sb[2][$];

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            m_tready[k] = (mode[k] == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    function automatic logic [26:0] beat(input logic [7:0] d, input logic l, input logic f,
                                         input logic [7:0] id, input logic [7:0] dest,
                                         input logic u);
        return {f, u, dest, id, l, d};
    endfunction

    always @(negedge clk) begin
        logic [25:0] act;
        logic [26:0] exp;
        #2;
        for (int k = 0; k < 2; k++) begin
            if (err[k]) errcnt[k]++;
            if (!rst) begin
                stall[k] = 1'b0;
            end else begin
                act = {m_tuser[k], m_tdest[k], m_tid[k], m_tlast[k], m_tdata[k]};
                if (stall[k]) begin
                    chk("stall_valid", 32'(m_tvalid[k]), 32'd1);
                    chk("stall_hold", 32'(act), 32'(prev[k]));
                end
                stall[k] = 1'b0;
                if (m_tvalid[k]) begin
                    if (sb[k].size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_beat dut%0d: got %h expected none", k, act);
                    end else begin
                        exp = sb[k][0];
                        chk("s_tready_in_word", 32'(s_tready[k]), 32'(m_tready[k] && exp[26]));
                        if (m_tready[k]) begin
                            void'(sb[k].pop_front());
                            chk("beat", 32'(act), 32'(exp[25:0]));
                            last_cyc[k] = cyc;
                        end else begin
                            stall[k] = 1'b1;
                            prev[k]  = act;
                        end
                    end
                end
            end
        end
    end

    // Model for generated words: contiguous keep run in emission order.
    task automatic push_word(input int k, input logic [31:0] d, input logic [3:0] kp,
                             input logic l, input logic [7:0] id, input logic [7:0] dest,
                             input logic u);
        int n = 0;
        logic run = 1'b1;
        logic [7:0] b;
        for (int i = 0; i < 4; i++) begin
            if (run && ((k == 1) ? kp[3-i] : kp[i])) n++;
            else run = 1'b0;
        end
        for (int i = 0; i < n; i++) begin
            b = (k == 1) ? d[8*(3-i) +: 8] : d[8*i +: 8];
            sb[k].push_back(beat(b, l && (i == n-1), i == n-1, id, dest, u));
        end
    endtask

    // Called at a negedge; returns at the negedge following the accepting edge.
    task automatic send(input int k, input logic [31:0] d, input logic [3:0] kp, input logic l,
                        input logic [7:0] id, input logic [7:0] dest, input logic u);
        int n = 0;
        logic got = 1'b0;
        s_tdata[k] = d;  s_tkeep[k] = kp; s_tlast[k] = l;
        s_tid[k] = id;   s_tdest[k] = dest; s_tuser[k] = u;
        s_tvalid[k] = 1'b1;
        while (!got && n < 200) begin
            #1 got = s_tready[k];
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        s_tvalid[k] = 1'b0;
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL send_timeout dut%0d: got no ready expected accept within 200 cycles", k);
        end
    endtask

    task automatic wait_empty(input int k);
        int n = 0;
        while (sb[k].size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 32'(sb[k].size()), 32'd0);
        @(negedge clk);
    endtask

    logic [3:0] ktab0[8] = '{4'hF, 4'hF, 4'hF, 4'h7, 4'hF, 4'h3, 4'hF, 4'h1};
    logic [3:0] ktab1[8] = '{4'hF, 4'hF, 4'hE, 4'hC, 4'hF, 4'h8, 4'hF, 4'hF};

    initial begin
        int c0;
        int e0;
        for (int k = 0; k < 2; k++) begin
            mode[k] = 0; errcnt[k] = 0; last_cyc[k] = 0; stall[k] = 1'b0;
            s_tvalid[k] = 1'b0; s_tdata[k] = '0; s_tkeep[k] = '0; s_tlast[k] = 1'b0;
            s_tid[k] = '0; s_tdest[k] = '0; s_tuser[k] = '0;
        end

        // Reset held for 3 cycles
        repeat (3) begin
            @(negedge clk); #2;
            for (int k = 0; k < 2; k++) begin
                chk("rst_s_tready", 32'(s_tready[k]), 32'd0);
                chk("rst_m_tvalid", 32'(m_tvalid[k]), 32'd0);
            end
        end
        chk("rst_outputs", {m_tdata[0], m_tid[0], m_tdest[0], 5'd0, m_tuser[0], m_tlast[0], err[0]}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        #2;
        chk("release_s_tready0", 32'(s_tready[0]), 32'd1);
        chk("release_s_tready1", 32'(s_tready[1]), 32'd1);
        @(negedge clk);

        // Single full word, LSB first
        sb[0].push_back(beat(8'h11, 0, 0, 8'h12, 8'h34, 1));
        sb[0].push_back(beat(8'h22, 0, 0, 8'h12, 8'h34, 1));
        sb[0].push_back(beat(8'h33, 0, 0, 8'h12, 8'h34, 1));
        sb[0].push_back(beat(8'h44, 1, 1, 8'h12, 8'h34, 1));
        send(0, 32'h44332211, 4'hF, 1, 8'h12, 8'h34, 1);
        c0 = cyc;
        #2;
        chk("first_byte_valid", 32'(m_tvalid[0]), 32'd1);
        chk("first_byte_data", 32'(m_tdata[0]), 32'h11);
        wait_empty(0);
        chk("single_word_span", 32'(last_cyc[0] - c0), 32'd3);

        // Back-to-back, MSB first
        sb[1].push_back(beat(8'hA1, 0, 0, 8'h05, 8'h21, 0));
        sb[1].push_back(beat(8'hA2, 0, 0, 8'h05, 8'h21, 0));
        sb[1].push_back(beat(8'hA3, 0, 0, 8'h05, 8'h21, 0));
        sb[1].push_back(beat(8'hA4, 0, 1, 8'h05, 8'h21, 0));
        sb[1].push_back(beat(8'hB1, 0, 0, 8'h05, 8'h21, 0));
        sb[1].push_back(beat(8'hB2, 0, 0, 8'h05, 8'h21, 0));
        sb[1].push_back(beat(8'hB3, 0, 0, 8'h05, 8'h21, 0));
        sb[1].push_back(beat(8'hB4, 1, 1, 8'h05, 8'h21, 0));
        send(1, 32'hA1A2A3A4, 4'hF, 0, 8'h05, 8'h21, 0);
        c0 = cyc;
        send(1, 32'hB1B2B3B4, 4'hF, 1, 8'h05, 8'h21, 0);
        wait_empty(1);
        chk("b2b_no_gaps", 32'(last_cyc[1] - c0), 32'd7);

        // Partial final words
        sb[0].push_back(beat(8'hAA, 0, 0, 8'h01, 8'h02, 0));
        sb[0].push_back(beat(8'hBB, 0, 0, 8'h01, 8'h02, 0));
        sb[0].push_back(beat(8'hCC, 1, 1, 8'h01, 8'h02, 0));
        send(0, 32'h00CCBBAA, 4'h7, 1, 8'h01, 8'h02, 0);
        c0 = cyc;
        wait_empty(0);
        chk("partial_span", 32'(last_cyc[0] - c0), 32'd2);
        sb[1].push_back(beat(8'hDD, 0, 0, 8'h03, 8'h04, 1));
        sb[1].push_back(beat(8'hEE, 0, 0, 8'h03, 8'h04, 1));
        sb[1].push_back(beat(8'hFF, 1, 1, 8'h03, 8'h04, 1));
        send(1, 32'hDDEEFF00, 4'hE, 1, 8'h03, 8'h04, 1);
        wait_empty(1);

        // Output backpressure
        mode[0] = 1;
        mode[1] = 1;
        for (int i = 0; i < 16; i++) begin
            logic [31:0] d;
            d = $urandom;
            push_word(0, d, ktab0[i%8], (i%4) == 3, 8'(i), 8'(i+64), 1'(i));
            send(0, d, ktab0[i%8], (i%4) == 3, 8'(i), 8'(i+64), 1'(i));
        end
        for (int i = 0; i < 8; i++) begin
            logic [31:0] d;
            d = $urandom;
            push_word(1, d, ktab1[i], (i%4) == 3, 8'(i+100), 8'(i), 1'(i+1));
            send(1, d, ktab1[i], (i%4) == 3, 8'(i+100), 8'(i), 1'(i+1));
        end
        wait_empty(0);
        wait_empty(1);
        mode[0] = 0;
        mode[1] = 0;
        @(negedge clk);

        // Null words
        e0 = errcnt[0];
        send(0, 32'hDEADBEEF, 4'h0, 1, 8'h00, 8'h00, 0);
        repeat (4) @(negedge clk);
        chk("null_last_pulse", 32'(errcnt[0] - e0), 32'd1);
        send(0, 32'hDEADBEEF, 4'h0, 0, 8'h00, 8'h00, 0);
        repeat (4) @(negedge clk);
        chk("null_nolast_quiet", 32'(errcnt[0] - e0), 32'd1);
        // Null-last accepted on the final byte cycle, then a 1-byte word
        sb[0].push_back(beat(8'h01, 0, 0, 8'h07, 8'h08, 0));
        sb[0].push_back(beat(8'h02, 0, 0, 8'h07, 8'h08, 0));
        sb[0].push_back(beat(8'h03, 0, 0, 8'h07, 8'h08, 0));
        sb[0].push_back(beat(8'h04, 0, 1, 8'h07, 8'h08, 0));
        sb[0].push_back(beat(8'h09, 1, 1, 8'h0A, 8'h0B, 1));
        send(0, 32'h04030201, 4'hF, 0, 8'h07, 8'h08, 0);
        send(0, 32'h12345678, 4'h0, 1, 8'h07, 8'h08, 0);
        send(0, 32'h00000009, 4'h1, 1, 8'h0A, 8'h0B, 1);
        wait_empty(0);
        chk("null_b2b_pulse", 32'(errcnt[0] - e0), 32'd2);

        // Reset after 2 of 4 bytes
        sb[0].push_back(beat(8'h55, 0, 0, 8'h0C, 8'h0D, 0));
        sb[0].push_back(beat(8'h66, 0, 0, 8'h0C, 8'h0D, 0));
        send(0, 32'h88776655, 4'hF, 1, 8'h0C, 8'h0D, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #2;
        chk("midrst_m_tvalid", 32'(m_tvalid[0]), 32'd0);
        chk("midrst_sb_popped", 32'(sb[0].size()), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (6) begin
            @(negedge clk); #2;
            chk("post_rst_idle", 32'(m_tvalid[0]), 32'd0);
        end

        chk("sb0_final", 32'(sb[0].size()), 32'd0);
        chk("sb1_final", 32'(sb[1].size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axis_word_serializer.md
Name: axis_word_serializer

Overview:
- Wide-to-narrow AXI-Stream adapter: accepts IN_BYTES-wide words and emits them one byte per beat on an 8-bit AXI-Stream source.
- Feeds byte-oriented async FIFOs and the USB byte path from wide producers such as ADC sample packers.
- Carries tid/tdest/tuser with every byte, honours tkeep for a partial final word, and places tlast on the last valid byte only.

Parameters:
- IN_BYTES, 4, input word width in bytes (>=2); input data width = 8*IN_BYTES.
- ID_WIDTH, 8, tid width.
- DEST_WIDTH, 8, tdest width.
- USER_WIDTH, 1, tuser width.
- MSB_FIRST, 0, 0 = byte 0 (bits 7:0) emitted first; 1 = byte IN_BYTES-1 emitted first.

Ports:
- clk  in  1  single clock for both sides.
- rst  in  1  synchronous, active-low reset.
- s_axis_tdata  in  8*IN_BYTES  input word.
- s_axis_tkeep  in  IN_BYTES  byte enables; contiguous from the first-emitted byte.
- s_axis_tvalid  in  1  input valid.
- s_axis_tready  out  1  input ready.
- s_axis_tlast  in  1  end of packet.
- s_axis_tid  in  ID_WIDTH  stream id.
- s_axis_tdest  in  DEST_WIDTH  destination.
- s_axis_tuser  in  USER_WIDTH  sideband.
- m_axis_tdata  out  8  output byte.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  output ready.
- m_axis_tlast  out  1  asserted on the last kept byte of a tlast word.
- m_axis_tid  out  ID_WIDTH  held tid.
- m_axis_tdest  out  DEST_WIDTH  held tdest.
- m_axis_tuser  out  USER_WIDTH  held tuser.
- err_null_last  out  1  one-cycle pulse: a word with tkeep==0 and tlast==1 was accepted.

Behaviour:
- Reset (rst==0 at a clk edge):
  - Holding register is cleared; byte index = 0; state = EMPTY.
  - m_axis_tvalid = 0, m_axis_tlast = 0, m_axis_tdata = 0, m_axis_tid, m_axis_tdest and m_axis_tuser = 0, err_null_last = 0.
  - s_axis_tready = 0 while rst is low.
  - s_axis_tready = 1 in the first cycle after rst returns high.
  - Reset mid-packet discards the held word and any unsent bytes; no tlast is emitted for it.
- State EMPTY:
  - s_axis_tready = 1 and m_axis_tvalid = 0.
  - On s handshake with tkeep != 0: capture data, tkeep, tlast, tid, tdest and tuser; idx = 0; go to SHIFT.
  - On s handshake with tkeep == 0: discard the word and stay in EMPTY. If tlast = 1, pulse err_null_last for exactly one cycle.
- State SHIFT:
  - m_axis_tvalid = 1.
  - m_axis_tdata = held byte at position idx (MSB_FIRST=0) or position IN_BYTES-1-idx (MSB_FIRST=1).
  - nkeep = count of contiguous set tkeep bits starting from the first-emitted byte. Non-contiguous tkeep is a protocol violation; only the contiguous run is emitted.
  - m_axis_tlast = held_last AND idx == nkeep-1.
  - Output sideband holds its captured value for every byte of the word.
  - m handshake with idx < nkeep-1: idx increments by 1.
  - m handshake with idx == nkeep-1: the word is done.
- Back-to-back:
  - s_axis_tready = (state==EMPTY) OR (m_axis_tready AND idx==nkeep-1), evaluated combinationally in SHIFT.
  - When the final byte handshake and a new s handshake occur in the same cycle, the new word loads and idx resets to 0 with no bubble. Sustained rate is 1 byte/clk.
  - A tkeep==0 word accepted in that same cycle returns the block to EMPTY.
- Latency: a word accepted at edge N presents its first byte at cycle N+1.
- Stalls: while m_axis_tvalid=1 and m_axis_tready=0, m_axis_tdata, m_axis_tlast and the sideband stay stable (AXI rule). The valid-before-ready rule holds; m_axis_tvalid never deasserts without a handshake.
- Index counter: width clog2(IN_BYTES), with no wrap beyond nkeep-1.
- Implementation size: roughly 150-250 lines of RTL.

Test Plan:
- Reset then idle: rst low for 3 cycles -> s_axis_tready=0 and m_axis_tvalid=0 throughout; s_axis_tready=1 on the first cycle after release.
- Single full word: IN_BYTES=4, tdata=0x44332211, tkeep=0xF, tlast=1, m_axis_tready=1 -> bytes 11,22,33,44 on consecutive cycles starting at N+1; tlast only on 44; s_axis_tready=1 in the 44 cycle.
- Back-to-back stream with MSB_FIRST=1: words 0xA1A2A3A4 then 0xB1B2B3B4 (tlast on the second), sink always ready -> A1..A4,B1..B4 with no gaps over 8 consecutive cycles; tlast on B4; tid=0x5 held on all bytes.
- Partial final word: tdata=0x00CCBBAA, tkeep=0x7, tlast=1 -> AA,BB,CC emitted; tlast on CC; 3 cycles total.
- Output backpressure: toggle m_axis_tready pseudo-randomly over 16 words -> scoreboard byte order matches, data is stable during stalls, s_axis_tready is never high mid-word before the last byte.
- Null-last and mid-packet reset:
  - Word with tkeep=0 and tlast=1 -> no output beat and exactly one err_null_last pulse.
  - Reset asserted after 2 of 4 bytes -> m_axis_tvalid=0 the next cycle; the remaining bytes are never emitted.
